// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg: shared instruction width and arbiter state encodings
package imem_port_arbiter_pkg;
  localparam int ISA_WIDTH = 32;
  localparam logic [1:0] IARB_RUN     = 2'd0;
  localparam logic [1:0] IARB_DRAIN   = 2'd1;
  localparam logic [1:0] IARB_LOAD    = 2'd2;
  localparam logic [1:0] IARB_RELEASE = 2'd3;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchroniser for a raw button plus a one-cycle rising-edge pulse
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sr;
  // sr[1:0] is the synchroniser, sr[2] the previous synchronised level
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else sr <= {sr[1:0], btn};
  end
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction ROM port between fetch and the UART loader; IMEM_ARB_TIMEOUT_EN adds a LOAD idle timeout
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = ISA_WIDTH,
  parameter int DEPTH          = 16384,
  parameter int DRAIN_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              uart_wr_en,
  input  logic [ADDR_W-1:0] uart_wr_addr,
  input  logic [DATA_W-1:0] uart_wr_data,
  input  logic              uart_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_reset_req,
  output logic              loader_active,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_err
);
  localparam int CNT_MAX = (DRAIN_CYCLES > RELEASE_CYCLES) ? DRAIN_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic load_evt;
  logic wr_ok;
`ifdef IMEM_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle;
`endif
  btn_edge_sync u_load_sync (
    .clk  (clock),
    .rst  (reset),
    .btn  (load_req),
    .pulse(load_evt)
  );
  assign wr_ok = (state == IARB_LOAD) && uart_wr_en && ({1'b0, uart_wr_addr} < DEPTH_W);
  assign mem_addr = (state == IARB_LOAD) ? uart_wr_addr : fetch_addr;
  assign mem_we = wr_ok;
  assign mem_wdata = uart_wr_data;
  assign cpu_hold = (state == IARB_DRAIN) || (state == IARB_LOAD);
  assign cpu_reset_req = (state == IARB_RELEASE);
  assign loader_active = (state == IARB_LOAD);
  // Sequencer: stall and drain fetch, hand the port to the loader, then hold the CPU in reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IARB_RUN;
      cnt <= '0;
      words_loaded <= '0;
      load_err <= 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
      idle <= '0;
`endif
    end else begin
      case (state)
        IARB_RUN: begin
          if (load_evt) begin
            state <= IARB_DRAIN;
            cnt <= '0;
          end
        end
        IARB_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= IARB_LOAD;
            cnt <= '0;
            words_loaded <= '0;
            load_err <= 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
            idle <= '0;
`endif
          end else cnt <= cnt + 1'b1;
        end
        IARB_LOAD: begin
          if (wr_ok && words_loaded != DEPTH_W) words_loaded <= words_loaded + 1'b1;
          if (uart_wr_en && !wr_ok) load_err <= 1'b1;
          if (uart_done) begin
            state <= IARB_RELEASE;
            cnt <= '0;
          end
`ifdef IMEM_ARB_TIMEOUT_EN
          if (uart_wr_en) idle <= '0;
          else if (idle == IDLE_LAST) begin
            load_err <= 1'b1;
            state <= IARB_RELEASE;
            cnt <= '0;
          end else idle <= idle + 1'b1;
`endif
        end
        default: begin
          if (cnt == RELEASE_LAST) state <= IARB_RUN;
          else cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and randomized checks of the ROM port arbiter against a behavioural model
module tb_imem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int DEPTH = 16384;
  localparam int DRAIN = 2;
  localparam int REL = 4;
  localparam int TMO = 100;
  localparam int P_RUN = 0, P_DRAIN = 1, P_LOAD = 2, P_REL = 3;
  logic clk = 0;
  logic rst = 1;
  logic load_req = 0;
  logic [AW-1:0] fetch_addr = '0;
  logic uart_wr_en = 0;
  logic [AW-1:0] uart_wr_addr = '0;
  logic [DW-1:0] uart_wr_data = '0;
  logic uart_done = 0;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic cpu_hold, cpu_reset_req, loader_active, load_err;
  logic [AW:0] words_loaded;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  bit armed = 0;
  int m_phase, m_left, m_words, m_idle;
  bit m_err;
  bit [2:0] samp;

  imem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN),
    .RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clk), .reset(rst), .load_req(load_req), .fetch_addr(fetch_addr),
    .uart_wr_en(uart_wr_en), .uart_wr_addr(uart_wr_addr), .uart_wr_data(uart_wr_data),
    .uart_done(uart_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_reset_req(cpu_reset_req), .loader_active(loader_active),
    .words_loaded(words_loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase with remaining-cycle budget; load event = request seen high two edges ago but low three edges ago
  always @(posedge clk) begin
    bit evt;
    evt = samp[1] && !samp[2];
    samp = {samp[1:0], load_req};
    if (rst) begin
      m_phase = P_RUN; m_words = 0; m_err = 0; m_idle = 0; samp = '0;
      armed = 1;
    end else if (m_phase == P_RUN) begin
      if (evt) begin m_phase = P_DRAIN; m_left = DRAIN; end
    end else if (m_phase == P_DRAIN) begin
      m_left--;
      if (m_left == 0) begin m_phase = P_LOAD; m_words = 0; m_err = 0; m_idle = 0; end
    end else if (m_phase == P_LOAD) begin
      if (uart_wr_en) begin
        if (uart_wr_addr < DEPTH) m_words = (m_words < DEPTH) ? m_words + 1 : DEPTH;
        else m_err = 1;
        m_idle = 0;
      end else m_idle++;
      if (uart_done) begin m_phase = P_REL; m_left = REL; end
`ifdef IMEM_ARB_TIMEOUT_EN
      if (m_idle == TMO) begin m_err = 1; m_phase = P_REL; m_left = REL; end
`endif
    end else begin
      m_left--;
      if (m_left == 0) m_phase = P_RUN;
    end
  end

  // Compare every cycle at the falling edge, once the model has seen a reset
  always @(negedge clk) begin
    if (armed) begin
      chk("mem_addr", mem_addr, (m_phase == P_LOAD) ? uart_wr_addr : fetch_addr);
      chk("mem_we", mem_we, m_phase == P_LOAD && uart_wr_en && uart_wr_addr < DEPTH);
      chk("mem_wdata", mem_wdata, uart_wr_data);
      chk("cpu_hold", cpu_hold, m_phase == P_DRAIN || m_phase == P_LOAD);
      chk("cpu_reset_req", cpu_reset_req, m_phase == P_REL);
      chk("loader_active", loader_active, m_phase == P_LOAD);
      chk("words_loaded", words_loaded, m_words);
      chk("load_err", load_err, m_err);
    end
    if (mem_we === 1'b1) we_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_addr = AW'($urandom);
    uart_wr_data = $urandom;
  endtask

  task automatic enter_load();
    int n = 0;
    load_req = 1;
    while (loader_active !== 1'b1 && n < 20) begin tick(); n++; end
    chk("enter_load", loader_active, 1);
    load_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0;
    tick(); tick();
    rst = 0;
    chk("reset_words", words_loaded, 0);
    chk("reset_hold", cpu_hold, 0);
    chk("reset_err", load_err, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      fetch_addr = AW'(i);
      #1;
      chk("sweep_addr", mem_addr, i);
    end
    // basic load: timing of hold, drain, 8 writes, release length
    load_req = 1;
    n = 0;
    while (cpu_hold !== 1'b1 && n < 10) begin tick(); n++; end
    chk("hold_latency", n, 3);
    n = 0;
    while (loader_active !== 1'b1 && n < 10) begin tick(); n++; end
    chk("drain_len", n, 2);
    load_req = 0;
    w0 = we_cnt;
    for (int i = 0; i < 8; i++) begin
      uart_wr_en = 1; uart_wr_addr = AW'(i);
      tick();
    end
    uart_wr_en = 0;
    chk("we_pulses", we_cnt - w0, 8);
    chk("words_8", words_loaded, 8);
    uart_done = 1; tick(); uart_done = 0;
    n = 0;
    while (cpu_reset_req === 1'b1 && n < 20) begin tick(); n++; end
    chk("release_len", n, 4);
    chk("back_run", cpu_hold | loader_active, 0);
    // out-of-range write then legal write
    repeat (3) tick();
    enter_load();
    uart_wr_en = 1; uart_wr_addr = AW'(16384);
    #1;
    chk("oor_we", mem_we, 0);
    tick();
    chk("oor_err", load_err, 1);
    chk("oor_words", words_loaded, 0);
    uart_wr_addr = AW'(3);
    tick();
    chk("legal_words", words_loaded, 1);
    chk("err_sticky", load_err, 1);
    // write together with done
    uart_wr_addr = AW'(5); uart_done = 1;
    tick();
    uart_wr_en = 0; uart_done = 0;
    chk("wr_done_words", words_loaded, 2);
    chk("wr_done_rel", cpu_reset_req, 1);
    repeat (6) tick();
    // writes in RUN, re-pulse in LOAD, reset in LOAD
    uart_wr_en = 1; uart_wr_addr = AW'(2);
    w0 = we_cnt;
    repeat (4) tick();
    chk("run_no_we", we_cnt - w0, 0);
    uart_wr_en = 0;
    enter_load();
    repeat (3) tick();
    load_req = 1; repeat (4) tick(); load_req = 0; repeat (4) tick();
    chk("repulse_load", loader_active, 1);
    rst = 1; uart_wr_en = 1; uart_wr_addr = AW'(1);
    tick();
    chk("rst_active", loader_active, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_err_words", {load_err, words_loaded}, 0);
    rst = 0; uart_wr_en = 0;
    repeat (3) tick();
    // idle in LOAD
    enter_load();
    repeat (120) tick();
`ifdef IMEM_ARB_TIMEOUT_EN
    chk("timeout_err", load_err, 1);
    chk("timeout_exit", loader_active, 0);
`else
    chk("no_timeout", loader_active, 1);
`endif
    uart_done = 1; tick(); uart_done = 0;
    repeat (6) tick();
    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      repeat ($urandom_range(3, 10)) begin
        uart_wr_en = $urandom_range(0, 1); uart_wr_addr = AW'($urandom);
        tick();
      end
      uart_wr_en = 0;
      enter_load();
      for (int k = 0; k < int'($urandom_range(5, 40)); k++) begin
        uart_wr_en = $urandom_range(0, 1);
        uart_wr_addr = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(16384, 32767)) : AW'($urandom_range(0, 200));
        load_req = ($urandom_range(0, 3) == 0);
        rst = (s == 5 && k == 4);
        tick();
      end
      rst = 0; load_req = 0;
      uart_done = 1; uart_wr_en = $urandom_range(0, 1);
      tick();
      uart_done = 0; uart_wr_en = 0;
      repeat (8) tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
